// File: rtl/sdram_init_refresh.sv
// rtl/sdram_init_refresh.sv - SDRAM power-up init and auto-refresh sequencer (SDRAM_REFRESH_BURST_EN: clear all refresh debt in one hold window)
module sdram_init_refresh #(
  parameter int          INIT_WAIT_CYCLES = 10000,
  parameter int          REFRESH_INTERVAL = 1560,
  parameter int          TRP_CYCLES       = 2,
  parameter int          TRFC_CYCLES      = 7,
  parameter int          TMRD_CYCLES      = 2,
  parameter logic [10:0] MODE_WORD        = 11'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_idle,
  output logic        hold,
  output logic        own_bus,
  output logic [2:0]  cmd,
  output logic        ba,
  output logic [10:0] addr,
  output logic [1:0]  dqm,
  output logic        cke,
  output logic        ready,
  output logic        refresh_overrun
);

  localparam logic [2:0] S_INIT_WAIT = 3'd0;
  localparam logic [2:0] S_INIT_PRE  = 3'd1;
  localparam logic [2:0] S_INIT_REF1 = 3'd2;
  localparam logic [2:0] S_INIT_REF2 = 3'd3;
  localparam logic [2:0] S_INIT_MRS  = 3'd4;
  localparam logic [2:0] S_IDLE      = 3'd5;
  localparam logic [2:0] S_DRAIN     = 3'd6;
  localparam logic [2:0] S_REF       = 3'd7;

  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_REF  = 3'b001;
  localparam logic [2:0] CMD_LMR  = 3'b000;

  // One shared phase counter covers the init wait and every post-command NOP run
  localparam int SHORT_MAX = TRP_CYCLES + TRFC_CYCLES + TMRD_CYCLES + 2;
  localparam int CNT_MAX   = (INIT_WAIT_CYCLES > SHORT_MAX) ? INIT_WAIT_CYCLES : SHORT_MAX;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int TMR_W     = $clog2(REFRESH_INTERVAL + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             ba_q, ba_d;
  logic [10:0]      addr_q, addr_d;
  logic             own_q, own_d;
  logic             hold_q, hold_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             ref_issue;
  logic             load_timer;
  logic             tick;

  // Sequencer: each command state issues its command, then waits out its NOP run
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    cmd_d      = CMD_NOP;
    ba_d       = 1'b0;
    addr_d     = 11'h000;
    own_d      = own_q;
    hold_d     = hold_q;
    ready_d    = ready_q;
    ref_issue  = 1'b0;
    load_timer = 1'b0;
    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q == CNT_W'(INIT_WAIT_CYCLES - 1)) begin
          cmd_d   = CMD_PRE;
          addr_d  = 11'h400;
          state_d = S_INIT_PRE;
          cnt_d   = '0;
        end
      end
      S_INIT_PRE: begin
        if (cnt_q == CNT_W'(TRP_CYCLES)) begin
          cmd_d   = CMD_REF;
          state_d = S_INIT_REF1;
          cnt_d   = '0;
        end
      end
      S_INIT_REF1: begin
        if (cnt_q == CNT_W'(TRFC_CYCLES)) begin
          cmd_d   = CMD_REF;
          state_d = S_INIT_REF2;
          cnt_d   = '0;
        end
      end
      S_INIT_REF2: begin
        if (cnt_q == CNT_W'(TRFC_CYCLES)) begin
          cmd_d   = CMD_LMR;
          addr_d  = MODE_WORD;
          state_d = S_INIT_MRS;
          cnt_d   = '0;
        end
      end
      S_INIT_MRS: begin
        if (cnt_q == CNT_W'(TMRD_CYCLES)) begin
          state_d    = S_IDLE;
          ready_d    = 1'b1;
          own_d      = 1'b0;
          hold_d     = 1'b0;
          load_timer = 1'b1;
          cnt_d      = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (pending_q != 3'd0) begin
          hold_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Bus ownership is taken one NOP cycle before REFRESH so it never flips on a command
        if (cnt_q == CNT_W'(TRP_CYCLES + 1)) begin
          cmd_d     = CMD_REF;
          ref_issue = 1'b1;
          state_d   = S_REF;
          cnt_d     = '0;
        end else if (!ctrl_idle) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(TRP_CYCLES)) begin
          own_d = 1'b1;
        end
      end
      S_REF: begin
        if (cnt_q == CNT_W'(TRFC_CYCLES)) begin
          cnt_d = '0;
`ifdef SDRAM_REFRESH_BURST_EN
          if (pending_q != 3'd0) begin
            cmd_d     = CMD_REF;
            ref_issue = 1'b1;
          end else begin
            state_d = S_IDLE;
            own_d   = 1'b0;
            hold_d  = 1'b0;
          end
`else
          state_d = S_IDLE;
          own_d   = 1'b0;
          hold_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_INIT_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Refresh timer and pending-debt counter; a simultaneous expiry and refresh cancel out
  always_comb begin
    tick      = ready_q && (timer_q == '0);
    timer_d   = timer_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (load_timer) begin
      timer_d = TMR_W'(REFRESH_INTERVAL - 1);
    end else if (ready_q) begin
      timer_d = tick ? TMR_W'(REFRESH_INTERVAL - 1) : timer_q - 1'b1;
    end
    if (tick && !ref_issue) begin
      if (pending_q == 3'd7) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = pending_q + 3'd1;
      end
    end else if (!tick && ref_issue) begin
      pending_d = pending_q - 3'd1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT_WAIT;
      cnt_q     <= '0;
      timer_q   <= '0;
      pending_q <= 3'd0;
      cmd_q     <= CMD_NOP;
      ba_q      <= 1'b0;
      addr_q    <= 11'h000;
      own_q     <= 1'b1;
      hold_q    <= 1'b1;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      own_q     <= own_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd             = cmd_q;
  assign ba              = ba_q;
  assign addr            = addr_q;
  assign own_bus         = own_q;
  assign hold            = hold_q;
  assign ready           = ready_q;
  assign refresh_overrun = overrun_q;
  assign dqm             = 2'b11;
  assign cke             = 1'b1;

endmodule
